// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage handshake bundle: imem req/ack, redirect, and instr valid/ready toward the core.
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Sequential fetch + prefetch FIFO; ack at edge N gives instr_valid in N+1; no request issued while full.
// FETCH_STALL_COUNT_EN adds the saturating stall_cycles starvation counter.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master bus
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] count_dec;
  logic [CW-1:0] count_inc;

  assign pop       = (count != '0) && bus.instr_ready;
  assign push      = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign count_dec = count - CW'(pop);
  assign count_inc = count_dec + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= 32'h0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // An un-acked request cannot be withdrawn, so it is drained in DROP first.
      if (state == DROP) begin
        fetch_pc <= bus.redirect_pc;
      end else if (state == REQ && !bus.imem_ack) begin
        state    <= DROP;
        fetch_pc <= bus.redirect_pc;
      end else begin
        req_addr <= bus.redirect_pc;
        fetch_pc <= bus.redirect_pc + 32'd4;
        state    <= REQ;
      end
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= push ? count_inc : count_dec;
      case (state)
        IDLE: begin
          if (count < FULL) begin
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (count_inc < FULL) begin
              req_addr <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= req_addr;
      dat_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = (state != IDLE);
  assign bus.imem_addr   = req_addr;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = dat_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0;
    end else if (bus.instr_ready && !bus.instr_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: memory model with programmable ack latency, pc/data scoreboard.
module tb_fetch_prefetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus();
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic [31:0] start_pc;
    int          lat;
    int          n;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int          lat    = 0;
  bit          mem_en = 1'b1;
  int          wcnt;
  logic [31:0] first_addr;

  assign bus.imem_ack   = mem_en && bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_A5A5;

  always @(posedge clk or negedge rst) begin
    if (!rst)                               wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                                    wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.dat = pc ^ 32'hA5A5_A5A5;
    return e;
  endfunction

  // Sampled mid-cycle: a valid&&ready seen here is consumed on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.imem_req && wcnt == 0) first_addr = bus.imem_addr;
      if (bus.imem_req && bus.imem_ack && wcnt > 0) chk("addr_stable", bus.imem_addr, first_addr);
      if (bus.instr_valid && bus.instr_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.instr_pc, e.pc);
        chk("sb_instr", bus.instr, e.dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d entries left, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(start + 32'(4 * i)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  vec_t vecs[4];

  initial begin
    vecs[0] = '{start_pc: 32'h0000_1000, lat: 0, n: 4};
    vecs[1] = '{start_pc: 32'h0000_2000, lat: 2, n: 3};
    vecs[2] = '{start_pc: 32'hFFFF_FFF8, lat: 0, n: 3};
    vecs[3] = '{start_pc: 32'h0000_0040, lat: 1, n: 5};

    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (3) tick();

    chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);

    // Reset start: one instruction per cycle, first valid in cycle 2.
    bus.instr_ready = 1'b1;
    push_seq(32'h0, 8);
    rst = 1'b1;
    tick();
    chk("start_req", {31'h0, bus.imem_req}, 32'h1);
    chk("start_addr", bus.imem_addr, 32'h0);
    chk("start_valid_c1", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    chk("start_valid_c2", {31'h0, bus.instr_valid}, 32'h1);
    repeat (8) tick();
    chk("throughput", sb.size(), 32'h0);
    wait_drain("start_drain", 20);

    // Backpressure: fill to DEPTH, then one pop at full.
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("bp_req_low", {31'h0, bus.imem_req}, 32'h0);
    chk("bp_valid", {31'h0, bus.instr_valid}, 32'h1);
    sb.push_back(mk(32'h0));
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("full_no_req_yet", {31'h0, bus.imem_req}, 32'h0);
    tick();
    chk("full_resume_req", {31'h0, bus.imem_req}, 32'h1);
    chk("full_resume_addr", bus.imem_addr, 32'h10);
    tick();
    push_seq(32'h4, 7);
    bus.instr_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Slow memory.
    lat = 3;
    do_reset();
    push_seq(32'h0, 6);
    wait_drain("slow_drain", 200);

    // Redirect while waiting on 0x8 (DROP path).
    do_reset();
    begin
      int k;
      k = 0;
      while (!(bus.imem_req && bus.imem_addr == 32'h8 && wcnt == 1 && !bus.imem_ack) && k < 60) begin
        tick();
        k++;
      end
      chk("redir_found_wait", {31'h0, (k < 60)}, 32'h1);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    sb.delete();
    tick();
    bus.redirect = 1'b0;
    chk("redir_valid_low", {31'h0, bus.instr_valid}, 32'h0);
    chk("redir_drop_addr", bus.imem_addr, 32'h8);
    push_seq(32'h100, 4);
    wait_drain("redir_drain", 100);

    // Redirect coinciding with pop and ack.
    lat = 0;
    do_reset();
    push_seq(32'h0, 4);
    wait_drain("coin_pre", 20);
    chk("coin_ack", {31'h0, bus.imem_ack}, 32'h1);
    chk("coin_valid", {31'h0, bus.instr_valid}, 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    sb.delete();
    tick();
    bus.redirect = 1'b0;
    chk("coin_valid_low", {31'h0, bus.instr_valid}, 32'h0);
    chk("coin_req_addr", bus.imem_addr, 32'h200);
    push_seq(32'h200, 4);
    wait_drain("coin_drain", 20);

    // Table of redirect targets and memory latencies, including the 2^32 wrap.
    for (int v = 0; v < 4; v++) begin
      lat             = vecs[v].lat;
      bus.redirect    = 1'b1;
      bus.redirect_pc = vecs[v].start_pc;
      sb.delete();
      tick();
      bus.redirect = 1'b0;
      chk("vec_valid_low", {31'h0, bus.instr_valid}, 32'h0);
      push_seq(vecs[v].start_pc, vecs[v].n);
      wait_drain("vec_drain", 100);
    end

`ifdef FETCH_STALL_COUNT_EN
    bus.instr_ready = 1'b0;
    mem_en          = 1'b0;
    do_reset();
    tick();
    bus.instr_ready = 1'b1;
    repeat (5) tick();
    bus.instr_ready = 1'b0;
    tick();
    chk("stall_count", stall_cycles, 32'd5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("stall_keep_redir", stall_cycles, 32'd5);
    mem_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
